data_mem_bank: RTL and testbench

//  Parametrised word-organised data memory for the MIPS datapath; the next-generation data RAM.
//  - Byte, halfword and word loads/stores; signed or unsigned load extension.
//  - Registered read with a one-cycle latency; req/ready handshake.
//  - Misalignment detection.
//  - Zero-fill sweep FSM, one word per cycle, after reset or on request.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_lane_fmt.sv | 39 +++
 rtl/data_mem_bank.sv | 108 ++++++++++
 tb/tb_data_mem_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory bank: access modes, FSM states and
// the alignment rule used by both the top level and the bench.
package dmem_pkg;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  function automatic logic is_aligned(input logic [1:0] mode, input logic [1:0] addr_lo);
    logic ok;
    case (mode)
      MODE_BYTE: ok = 1'b1;
      MODE_HALF: ok = ~addr_lo[0];
      MODE_WORD: ok = (addr_lo == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting for one access: merges store data into the old word
// and extracts/extends the addressed lane for loads.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  mode_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sext_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    merged_o = old_word_i;
    case (mode_i)
      MODE_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      MODE_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      MODE_WORD: merged_o = wdata_i;
      default:   merged_o = old_word_i;
    endcase
  end

  always_comb begin
    byte_v = old_word_i[{addr_lo_i, 3'b000} +: 8];
    half_v = old_word_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (mode_i)
      MODE_BYTE: load_o = sext_i ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
      MODE_HALF: load_o = sext_i ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
      MODE_WORD: load_o = old_word_i;
      default:   load_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_bank.sv
// Word-organised data RAM with byte/half/word access, one-cycle registered
// read, misalignment reporting and a one-word-per-cycle zero-fill sweep.
//
// state    | meaning
// ST_IDLE  | accepting requests, ready_o high
// ST_SWEEP | writing zero to mem[ptr_q], one word per cycle, busy_o high
module data_mem_bank
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              clr_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        mode_i,
  input  logic              sext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              clear_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              rvalid_q, err_q;
  logic [31:0]       rdata_q;

  logic [31:0]       mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [31:0]       old_word, merged, load_data;
  logic              accept, legal, wr_en, rd_en;

  assign idx      = addr_i[ADDR_W-1:2];
  assign old_word = mem[idx];
  assign legal    = is_aligned(mode_i, addr_i[1:0]);

  // ready is forced low while reset is held, even when resetting into IDLE
  assign ready_o  = (state_q == ST_IDLE) && clr_n_i;
  assign accept   = req_i && ready_o && !clear_i;
  assign wr_en    = accept && we_i && legal;
  assign rd_en    = accept && !we_i;

  dmem_lane_fmt u_fmt (
    .old_word_i (old_word),
    .wdata_i    (wdata_i),
    .mode_i     (mode_i),
    .addr_lo_i  (addr_i[1:0]),
    .sext_i     (sext_i),
    .merged_o   (merged),
    .load_o     (load_data)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      if (CLEAR_ON_RESET) state_q <= ST_SWEEP;
      else                state_q <= ST_IDLE;
      ptr_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rvalid_q <= rd_en;
      err_q    <= accept && !legal;
      if (rd_en) rdata_q <= legal ? load_data : '0;
    end
  end

  // Array has no reset; the sweep is the only way it gets zeroed.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_SWEEP) mem[ptr_q] <= '0;
    else if (wr_en)          mem[idx]   <= merged;
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign busy_o   = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_data_mem_bank.sv
// Self-checking bench for data_mem_bank (ADDR_W=6, 16 words): table of access
// vectors with a per-cycle expectation queue, plus sweep/reset sequences.
module tb_data_mem_bank;

  localparam logic [1:0] MB = 2'b00, MH = 2'b01, MW = 2'b10, MX = 2'b11;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        req = 1'b0, we = 1'b0, sext = 1'b0, clear = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, rvalid, err, busy;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_bank #(.ADDR_W(6), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_i    (clk),
    .clr_n_i  (clr_n),
    .req_i    (req),
    .we_i     (we),
    .mode_i   (mode),
    .sext_i   (sext),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .clear_i  (clear),
    .ready_o  (ready),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .busy_o   (busy)
  );

  typedef struct {
    logic        req, we;
    logic [1:0]  mode;
    logic        sext;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        exp_rv, exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          id;
    logic        rv, err;
    logic [31:0] rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [1:0] m,
                              input logic s, input logic [5:0] a, input logic [31:0] d,
                              input logic rv, input logic e, input logic [31:0] rd);
    vec_t v;
    v = '{req: r, we: w, mode: m, sext: s, addr: a, wdata: d,
          exp_rv: rv, exp_err: e, exp_rd: rd};
    return v;
  endfunction

  task automatic drive(input logic r, input logic w, input logic [1:0] m, input logic s,
                       input logic [5:0] a, input logic [31:0] d, input logic c);
    req = r; we = w; mode = m; sext = s; addr = a; wdata = d; clear = c;
  endtask

  task automatic store(input logic [1:0] m, input logic [5:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, m, 1'b0, a, d, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, MW, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic load_chk(input string nm, input logic [1:0] m, input logic s,
                          input logic [5:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, m, s, a, '0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, MW, 1'b0, '0, '0, 1'b0);
    chk({nm, ".rvalid"}, {31'b0, rvalid}, 32'd1);
    chk({nm, ".rdata"}, rdata, exp);
  endtask

  // Counts consecutive negedge samples with busy high, starting at the current one.
  task automatic sweep_len(input string nm);
    int   n;
    logic rdy_bad;
    n = 0;
    rdy_bad = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      if (ready !== 1'b0) rdy_bad = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({nm, ".busy_cycles"}, n, 16);
    chk({nm, ".ready_low"}, {31'b0, rdy_bad}, 32'd0);
    chk({nm, ".ready_after"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_rd;
    exp_t        e;
    vec_t        v;

    // Reset and power-up sweep
    #1 clr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy",   {31'b0, busy},   32'd1);
    chk("rst.ready",  {31'b0, ready},  32'd0);
    chk("rst.rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst.err",    {31'b0, err},    32'd0);
    chk("rst.rdata",  rdata,           32'd0);
    clr_n = 1'b1;
    sweep_len("por");

    // Table: inputs for one cycle, expected outputs visible at the next negedge
    vecs.push_back(mk(1, 0, MW, 0, 6'h3C, 32'h0,        1, 0, 32'h00000000));
    vecs.push_back(mk(1, 1, MW, 0, 6'h10, 32'h80007F80, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, MB, 1, 6'h10, 32'h0,        1, 0, 32'hFFFFFF80));
    vecs.push_back(mk(1, 0, MB, 1, 6'h11, 32'h0,        1, 0, 32'h0000007F));
    vecs.push_back(mk(1, 0, MB, 1, 6'h12, 32'h0,        1, 0, 32'h00000000));
    vecs.push_back(mk(1, 0, MB, 1, 6'h13, 32'h0,        1, 0, 32'hFFFFFF80));
    vecs.push_back(mk(1, 0, MB, 0, 6'h10, 32'h0,        1, 0, 32'h00000080));
    vecs.push_back(mk(1, 1, MH, 0, 6'h22, 32'h0000BEEF, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, MW, 0, 6'h20, 32'h0,        1, 0, 32'hBEEF0000));
    vecs.push_back(mk(1, 0, MH, 1, 6'h22, 32'h0,        1, 0, 32'hFFFFBEEF));
    vecs.push_back(mk(1, 0, MH, 0, 6'h22, 32'h0,        1, 0, 32'h0000BEEF));
    vecs.push_back(mk(1, 0, MH, 1, 6'h20, 32'h0,        1, 0, 32'h00000000));
    vecs.push_back(mk(1, 1, MW, 0, 6'h05, 32'hDEADBEEF, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, MW, 0, 6'h04, 32'h0,        1, 0, 32'h00000000));
    vecs.push_back(mk(1, 0, MH, 1, 6'h03, 32'h0,        1, 1, 32'h00000000));
    vecs.push_back(mk(0, 0, MW, 0, 6'h10, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 0, MX, 0, 6'h10, 32'h0,        1, 1, 32'h00000000));
    vecs.push_back(mk(1, 0, MW, 0, 6'h10, 32'h0,        1, 0, 32'h80007F80));
    vecs.push_back(mk(1, 1, MB, 0, 6'h11, 32'hFFFFFFAA, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, MW, 0, 6'h10, 32'h0,        1, 0, 32'h8000AA80));
    vecs.push_back(mk(1, 1, MH, 0, 6'h12, 32'h00001234, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, MW, 0, 6'h10, 32'h0,        1, 0, 32'h1234AA80));
    vecs.push_back(mk(1, 0, MB, 1, 6'h12, 32'h0,        1, 0, 32'h00000034));
    vecs.push_back(mk(1, 0, MW, 1, 6'h13, 32'h0,        1, 1, 32'h00000000));
    vecs.push_back(mk(1, 0, MW, 1, 6'h20, 32'h0,        1, 0, 32'hBEEF0000));
    vecs.push_back(mk(1, 1, MW, 0, 6'h3C, 32'hFFFFFFFF, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, MB, 0, 6'h3F, 32'h0,        1, 0, 32'h000000FF));
    vecs.push_back(mk(1, 0, MH, 1, 6'h3E, 32'h0,        1, 0, 32'hFFFFFFFF));
    vecs.push_back(mk(1, 0, MH, 0, 6'h3C, 32'h0,        1, 0, 32'h0000FFFF));

    last_rd = 32'h0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.req) chk($sformatf("v%0d.ready", i), {31'b0, ready}, 32'd1);
      drive(v.req, v.we, v.mode, v.sext, v.addr, v.wdata, 1'b0);
      e.id  = i;
      e.rv  = v.exp_rv;
      e.err = v.exp_err;
      e.rd  = v.exp_rv ? v.exp_rd : last_rd;
      last_rd = e.rd;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d.rvalid", e.id), {31'b0, rvalid}, {31'b0, e.rv});
      chk($sformatf("v%0d.err", e.id),    {31'b0, err},    {31'b0, e.err});
      chk($sformatf("v%0d.rdata", e.id),  rdata,           e.rd);
    end
    drive(1'b0, 1'b0, MW, 1'b0, '0, '0, 1'b0);

    // clear together with req: request dropped, sweep wipes stored data
    store(MW, 6'h30, 32'h12345678);
    load_chk("pre_clr", MW, 1'b0, 6'h30, 32'h12345678);
    drive(1'b1, 1'b0, MW, 1'b0, 6'h30, '0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, MW, 1'b0, '0, '0, 1'b0);
    chk("clr.rvalid", {31'b0, rvalid}, 32'd0);
    chk("clr.busy",   {31'b0, busy},   32'd1);
    sweep_len("clr");
    load_chk("post_clr30", MW, 1'b0, 6'h30, 32'h0);
    load_chk("post_clr10", MW, 1'b0, 6'h10, 32'h0);

    // Reset in the middle of a sweep
    store(MW, 6'h18, 32'hCAFEF00D);
    load_chk("pre_rst", MW, 1'b0, 6'h18, 32'hCAFEF00D);
    drive(1'b0, 1'b0, MW, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    clear = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid.busy", {31'b0, busy}, 32'd1);
    #2 clr_n = 1'b0;
    #1;
    chk("mid_rst.busy",   {31'b0, busy},   32'd1);
    chk("mid_rst.ready",  {31'b0, ready},  32'd0);
    chk("mid_rst.rvalid", {31'b0, rvalid}, 32'd0);
    chk("mid_rst.err",    {31'b0, err},    32'd0);
    chk("mid_rst.rdata",  rdata,           32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    sweep_len("restart");
    load_chk("post_rst18", MW, 1'b0, 6'h18, 32'h0);
    load_chk("post_rst3c", MW, 1'b0, 6'h3C, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
